// File: rtl/mux_rr_pkg.sv
// mux_rr_pkg: channel count, channel index type and output-stage state encoding
package mux_rr_pkg;
    localparam int NUM_CH = 4;
    typedef logic [1:0] ch_idx_t;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: combinational 4-way round-robin, searching upward from i_ptr+1
module rr_arbiter4
    import mux_rr_pkg::*;
(
    input  logic [NUM_CH-1:0] i_req,
    input  ch_idx_t           i_ptr,
    output logic [NUM_CH-1:0] o_grant,
    output ch_idx_t           o_idx
);
    ch_idx_t w_c;
    logic    w_found;

    // first requester after the last granted channel wins, wrapping 4->1
    always_comb begin
        o_grant = '0;
        o_idx   = i_ptr;
        w_found = 1'b0;
        w_c     = i_ptr;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_c = i_ptr + ch_idx_t'(i);
            if (!w_found && i_req[w_c]) begin
                w_found    = 1'b1;
                o_grant[w_c] = 1'b1;
                o_idx      = w_c;
            end
        end
    end
endmodule

// File: rtl/mux_rr.sv
// mux_rr: 4-to-1 round-robin mux with lockable grant and a one-beat registered output
module mux_rr
    import mux_rr_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic             valid1,
    input  logic             valid2,
    input  logic             valid3,
    input  logic             valid4,
    output logic             ready1,
    output logic             ready2,
    output logic             ready3,
    output logic             ready4,
    input  logic             lock,
    input  logic [1:0]       ctrl,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_sel,
    output logic [CNT_W-1:0] count
);
    state_t             r_state;
    logic [WIDTH-1:0]   r_out;
    ch_idx_t            r_sel;
    ch_idx_t            r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_CH-1:0]  w_req;
    logic [NUM_CH-1:0]  w_grant;
    ch_idx_t            w_idx;
    logic               w_load;
    logic               w_accept;
    logic [WIDTH-1:0]   w_in [NUM_CH];

    assign w_in     = '{in1, in2, in3, in4};
    assign w_req    = {valid4, valid3, valid2, valid1} & (lock ? (NUM_CH'(1) << ctrl) : {NUM_CH{1'b1}});
    assign w_load   = (r_state == EMPTY) | out_ready;
    assign w_accept = w_load & (|w_grant);

    rr_arbiter4 u_arb (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    // ready is suppressed during reset so no beat is handed off while held
    assign {ready4, ready3, ready2, ready1} = {NUM_CH{rst_n & w_load}} & w_grant;

    // output stage FSM: load on accept, drain to EMPTY when consumed with nothing new
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_out   <= '0;
            r_sel   <= '0;
            r_ptr   <= 2'd3;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_state <= FULL;
            r_out   <= w_in[w_idx];
            r_sel   <= w_idx;
            r_ptr   <= w_idx;
            r_cnt   <= r_cnt + 1'b1;
        end else if (out_ready) begin
            r_state <= EMPTY;
        end
    end

    assign out       = r_out;
    assign out_sel   = r_sel;
    assign out_valid = (r_state == FULL);
    assign count     = r_cnt;
endmodule

// File: doc/mux_rr.md
MUX_RR -- requirements
Module: mux_rr

Interface
REQ-001 The parameter list SHALL be: WIDTH, default 64, data width of every channel and of the output.
REQ-002 The parameter list SHALL be: CNT_W, default 16, width of the accepted-beat counter.
REQ-003 Port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Ports: in1..in4  input  WIDTH each  channel data.
REQ-006 Ports: valid1..valid4  input  1 each  channel data valid.
REQ-007 Ports: ready1..ready4  output  1 each  channel beat accepted this cycle.
REQ-008 Port: lock  input  1  when high, restricts grant to the channel selected by ctrl.
REQ-009 Port: ctrl  input  2  locked channel index; 0 selects channel 1 through 3 selecting channel 4.
REQ-010 Port: out  output  WIDTH  registered output data.
REQ-011 Port: out_valid  output  1  out holds a beat.
REQ-012 Port: out_ready  input  1  downstream accepts the beat.
REQ-013 Port: out_sel  output  2  source channel index of out, same encoding as ctrl, so it can drive a downstream demux ctrl.
REQ-014 Port: count  output  CNT_W  number of beats accepted from all channels, wrapping.

Function
REQ-015 The output stage SHALL be a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 load = !out_valid | out_ready; a channel SHALL be accepted only in a cycle where load=1.
REQ-017 Eligible channels: if lock=0, every channel with valid high; if lock=1, only channel ctrl+1, and only if its valid is high.
REQ-018 Grant SHALL be round-robin over eligible channels, searching upward from channel ptr+1 and wrapping 4->1.
REQ-019 readyN SHALL be high iff load=1 and channel N is granted; at most one readyN SHALL be high per cycle.
REQ-020 On accept from channel k: out<=ink, out_sel<=k-1, out_valid<=1, ptr<=k-1, count<=count+1; latency from accept to out_valid is 1 cycle.
REQ-021 In FULL with out_ready=1 and no eligible channel, the FSM SHALL go to EMPTY; with an eligible channel it SHALL stay FULL and load the new beat, giving back-to-back throughput of 1 beat/cycle.
REQ-022 In FULL with out_ready=0: out, out_sel and out_valid SHALL hold, and all readyN SHALL be 0.
REQ-023 readyN SHALL depend combinationally on validN, lock, ctrl, out_ready and state; out, out_sel and out_valid SHALL be registered only.
REQ-024 A change of lock or ctrl SHALL affect the grant in the same cycle; a beat already in out is unaffected.
REQ-025 count SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-026 When lock=0, ptr SHALL be updated only on accept; when lock=1 and a beat is accepted, ptr SHALL be updated to ctrl.

Reset
REQ-027 While rst_n=0: out_valid=0, out=0, out_sel=0, count=0, ptr=3 (channel 1 highest priority after reset), FSM=EMPTY, all readyN=0.
REQ-028 Reset asserted mid-transfer SHALL drop the held beat with no partial output; the first accept after deassertion SHALL follow REQ-027 priority.

Structure
REQ-029 A shared package mux_rr_pkg SHALL hold NUM_CH=4, the 2-bit channel-index type, and the FSM state encoding (EMPTY, FULL).
REQ-030 The round-robin grant logic SHALL be one sub-module rr_arbiter4: 4-bit request and 2-bit ptr in, one-hot grant and 2-bit index out, purely combinational.

Verification
REQ-031 Reset then single beat: valid2=1, in2=0x0000_0000_0000_00AA, out_ready=1 -> ready2 high for one cycle; the next cycle has out=0xAA, out_sel=1, out_valid=1, count=1.
REQ-032 All four valid and out_ready=1 held for 8 cycles, in ports with distinct data -> out_sel sequence 0,1,2,3,0,1,2,3 after reset, and count=8.
REQ-033 Backpressure: out_ready=0 for 5 cycles while FULL, valid1=1 -> out stable, ready1=0 throughout; out_ready=1 -> the held beat is drained and in1 is loaded in the same cycle.
REQ-034 Lock: lock=1, ctrl=2, all valid -> only ready3 ever asserts; out_sel=2 on every beat.
REQ-035 Wrap: CNT_W=4, 17 accepted beats -> count=1. Reset asserted while FULL -> out_valid=0 immediately (asynchronously), count=0.
